// File: rtl/spi_agc_arbiter.sv
// +--------------------------------------------------------------------------+
// | spi_agc_arbiter: round-robin arbiter for two AGC requesters feeding a     |
// | single mode-0 SPI master. Revision: 1.0                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_agc_arbiter #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  output logic        busy,
  output logic        grant_id,
  output logic        done
);

  localparam logic [7:0] c_div_term   = 8'(CLK_DIV - 1);
  localparam logic [7:0] c_setup_term = 8'(SETUP_CYC - 1);
  localparam logic [7:0] c_hold_term  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] c_gap_term   = 8'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic [15:0] shreg_q, shreg_d;
  logic        last_q, last_d;
  logic        grant_q, grant_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        w_accept;
  logic        w_pick;

  // Contested requests go to whoever was not served last.
  always_comb begin
    w_pick   = req1_valid;
    if (req0_valid && req1_valid) begin
      w_pick = ~last_q;
    end
    w_accept = (state_q == S_IDLE) && !ARESET && (req0_valid || req1_valid);
  end

  assign req0_ready = w_accept && !w_pick;
  assign req1_ready = w_accept && w_pick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    grant_d = grant_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          shreg_d = w_pick ? req1_data : req0_data;
          last_d  = w_pick;
          grant_d = w_pick;
          cnt_d   = 8'd0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == c_setup_term) begin
          cnt_d   = 8'd0;
          bit_d   = 5'd0;
          phase_d = 1'b0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == c_div_term) begin
          cnt_d = 8'd0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == 5'd15) begin
            phase_d = 1'b0;
            state_d = S_HOLD;
          end else begin
            // Next bit is presented at the start of its low phase.
            phase_d = 1'b0;
            bit_d   = bit_q + 5'd1;
            shreg_d = {shreg_q[14:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == c_hold_term) begin
          cnt_d   = 8'd0;
          done_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == c_gap_term) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Pins are decoded from the next state so they launch glitch-free from flops.
    cs_n_d = !((state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD));
    sclk_d = (state_d == S_SHIFT) && phase_d;
    mosi_d = ((state_d == S_SETUP) || (state_d == S_SHIFT)) && shreg_d[15];
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 5'd0;
      phase_q <= 1'b0;
      shreg_q <= 16'd0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign spi_sclk = sclk_q;
  assign spi_cs_n = cs_n_q;
  assign spi_mosi = mosi_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign done     = done_q;

endmodule

`default_nettype wire
